sva_fail_logger: RTL and testbench

Downstream collector for concurrent-assertion results in the lint/regression testbenches. Each checked property drives a one-cycle failure strobe from its `else` action block. This block queues the strobes as timestamped events in a FIFO and keeps saturating per-check failure counters, so the regression harness can drain and report failures in order. It is synthesizable, so the same collector also serves emulation builds.

---
 rtl/sva_fail_logger.sv | 95 +++++++++
 tb/tb_sva_fail_logger.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sva_fail_logger.sv
// sva_fail_logger: queues assertion-failure strobes as timestamped FIFO events
// and keeps saturating per-check failure counters plus sticky any/dropped flags.
module sva_fail_logger #(
  parameter  int NUM_CHK = 4,
  parameter  int DEPTH   = 8,
  parameter  int TS_W    = 16,
  parameter  int CNT_W   = 8,
  localparam int ID_W    = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CHK-1:0]       fail_i,
  input  logic                     clr_i,
  output logic                     ev_valid_o,
  input  logic                     ev_ready_i,
  output logic [ID_W-1:0]          ev_id_o,
  output logic [TS_W-1:0]          ev_ts_o,
  output logic [NUM_CHK*CNT_W-1:0] fail_cnt_o,
  output logic                     any_fail_o,
  output logic                     dropped_o
);
  logic [TS_W-1:0]      r_ts;
  logic [NUM_CHK-1:0]   r_pend;
  logic [TS_W-1:0]      r_pts [NUM_CHK];
  logic [CNT_W-1:0]     r_cnt [NUM_CHK];
  logic [ID_W+TS_W-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wr, r_rd;
  logic                 r_any, r_drop;
  logic                 w_empty, w_full, w_pop, w_push, w_hit, w_drop;
  logic [ID_W-1:0]      w_sel;
  logic [NUM_CHK-1:0]   w_take, w_arm;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && ev_ready_i;
  assign w_push  = w_hit && (!w_full || w_pop);
  // Lowest pending index wins; a failure on a check not being pushed merges into its pending slot.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int k = NUM_CHK - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_sel = ID_W'(k);
        w_hit = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CHK; k++) w_take[k] = w_push && (w_sel == ID_W'(k));
    w_arm  = fail_i & ~(r_pend & ~w_take);
    w_drop = |(fail_i & r_pend & ~w_take);
  end
  assign ev_valid_o           = !w_empty;
  assign {ev_id_o, ev_ts_o}   = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign any_fail_o           = r_any;
  assign dropped_o            = r_drop;
  for (genvar g = 0; g < NUM_CHK; g++) begin : g_cnt
    assign fail_cnt_o[g*CNT_W +: CNT_W] = r_cnt[g];
  end
  always_ff @(posedge clk) begin
    if (!rst && !clr_i && w_push) r_mem[r_wr[AW-1:0]] <= {w_sel, r_pts[w_sel]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts   <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_any  <= 1'b0;
      r_drop <= 1'b0;
      r_pend <= '0;
      for (int k = 0; k < NUM_CHK; k++) begin
        r_pts[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (clr_i) begin
        r_wr   <= '0;
        r_rd   <= '0;
        r_any  <= 1'b0;
        r_drop <= 1'b0;
        r_pend <= '0;
        for (int k = 0; k < NUM_CHK; k++) r_cnt[k] <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + (AW+1)'(1);
        if (w_pop) r_rd <= r_rd + (AW+1)'(1);
        if (|fail_i) r_any <= 1'b1;
        if (w_drop) r_drop <= 1'b1;
        r_pend <= (r_pend & ~w_take) | fail_i;
        for (int k = 0; k < NUM_CHK; k++) begin
          if (w_arm[k]) r_pts[k] <= r_ts;
          if (fail_i[k] && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sva_fail_logger.sv
// tb_sva_fail_logger: directed plus random stimulus against a queue-based
// reference model; a negedge monitor pops expected events on each handshake.
module tb_sva_fail_logger;
  localparam int N = 4, D = 8, TW = 4, CW = 4;
  logic          clk = 1'b0, rst = 1'b1, clr_i = 1'b0, ev_ready_i = 1'b0;
  logic [N-1:0]  fail_i = '0;
  logic          ev_valid_o, any_fail_o, dropped_o;
  logic [1:0]    ev_id_o;
  logic [TW-1:0] ev_ts_o;
  logic [N*CW-1:0] fail_cnt_o;
  int vectors = 0, miscompares = 0;
  typedef struct {int id; int ts;} ev_t;
  ev_t mq[$];
  int pend[N], pts[N], cnt[N];
  int anyf, drop, tsm;

  sva_fail_logger #(.NUM_CHK(N), .DEPTH(D), .TS_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fail_i(fail_i), .clr_i(clr_i),
    .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i), .ev_id_o(ev_id_o),
    .ev_ts_o(ev_ts_o), .fail_cnt_o(fail_cnt_o), .any_fail_o(any_fail_o),
    .dropped_o(dropped_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    anyf = 0;
    drop = 0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 0;
      cnt[k] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] f, input logic c);
    int t;
    t = tsm;
    tsm = (tsm + 1) % (1 << TW);
    if (c) begin
      model_clear();
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (pend[k] != 0) begin
        if (mq.size() < D) begin
          mq.push_back('{k, pts[k]});
          pend[k] = 0;
        end
        break;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (f[k]) begin
        cnt[k] = cnt[k] < (1 << CW) - 1 ? cnt[k] + 1 : cnt[k];
        anyf = 1;
        if (pend[k] != 0) drop = 1;
        else begin
          pend[k] = 1;
          pts[k] = t;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] f, input logic r, input logic c);
    fail_i = f;
    ev_ready_i = r;
    clr_i = c;
    @(posedge clk);
    #1;
    if (!rst) model_edge(f, c);
  endtask

  always @(negedge clk) begin
    chk("valid", int'(ev_valid_o), int'(mq.size() > 0));
    if (mq.size() > 0 && ev_ready_i) begin
      chk("ev_id", int'(ev_id_o), mq[0].id);
      chk("ev_ts", int'(ev_ts_o), mq[0].ts);
      void'(mq.pop_front());
    end
    for (int k = 0; k < N; k++) chk($sformatf("cnt%0d", k), int'(fail_cnt_o[k*CW +: CW]), cnt[k]);
    chk("any_fail", int'(any_fail_o), anyf);
    chk("dropped", int'(dropped_o), drop);
  end

  initial begin
    model_clear();
    tsm = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    while (tsm != 12) step('0, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    repeat (4) step('0, 1'b1, 1'b0);
    while (tsm != 5) step('0, 1'b1, 1'b0);
    step(4'b1011, 1'b1, 1'b0);
    repeat (6) step('0, 1'b1, 1'b0);
    repeat (D) step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);
    repeat (12) step('0, 1'b1, 1'b0);
    repeat (20) step(4'b1000, 1'b1, 1'b0);
    repeat (4) step('0, 1'b1, 1'b0);
    step(4'b0111, 1'b0, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    repeat (3) step('0, 1'b1, 1'b0);
    step(4'b1101, 1'b0, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", int'(ev_valid_o), 0);
    chk("rst_id", int'(ev_id_o), 0);
    chk("rst_ts", int'(ev_ts_o), 0);
    chk("rst_cnt", int'(fail_cnt_o), 0);
    chk("rst_any", int'(any_fail_o), 0);
    chk("rst_drop", int'(dropped_o), 0);
    model_clear();
    tsm = 0;
    repeat (2) step('0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
           (i % 200 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
           $urandom_range(0, 199) == 0);
    end
    repeat (20) step('0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
